// File: rtl/dec_addr_sequencer.sv
// Select-line sequencer for the 2:4 decoder: steps {a,b} through four slots of PRESCALE cycles.
// Define DEC_ADDR_SEQ_GRAY_EN to emit the codes in Gray order (00,01,11,10) instead of binary.
module dec_addr_sequencer #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       loop,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic       slot_valid,
  output logic       busy,
  output logic       done,
  output logic [1:0] slot_idx
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] PcntMax = CNT_W'(PRESCALE - 1);

  state_e           state_q;
  logic [CNT_W-1:0] pcnt_q;
  logic [1:0]       slot_q;
  logic [1:0]       slot_nxt;
  logic             loop_q;

  // Slot index to select-line code.
  function automatic logic [1:0] sel_code(input logic [1:0] idx);
`ifdef DEC_ADDR_SEQ_GRAY_EN
    return idx ^ {1'b0, idx[1]};
`else
    return idx;
`endif
  endfunction

  // Slot 3 naturally wraps to 0, which is exactly the loop-mode restart slot.
  always_comb begin
    slot_nxt = slot_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pcnt_q     <= '0;
      slot_q     <= 2'd0;
      loop_q     <= 1'b0;
      a          <= 1'b0;
      b          <= 1'b0;
      slot_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      slot_idx   <= 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_q    <= StRun;
            loop_q     <= loop;
            pcnt_q     <= '0;
            slot_q     <= 2'd0;
            {a, b}     <= sel_code(2'd0);
            slot_valid <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            slot_idx   <= 2'd0;
          end
        end

        StRun: begin
          if (abort) begin
            state_q    <= StIdle;
            pcnt_q     <= '0;
            slot_q     <= 2'd0;
            loop_q     <= 1'b0;
            a          <= 1'b0;
            b          <= 1'b0;
            slot_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            slot_idx   <= 2'd0;
          end else if (pcnt_q == PcntMax) begin
            pcnt_q <= '0;
            if (slot_q == 2'd3 && !loop_q) begin
              state_q    <= StDone;
              slot_q     <= 2'd0;
              a          <= 1'b0;
              b          <= 1'b0;
              slot_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              slot_idx   <= 2'd0;
            end else begin
              // In loop mode the done pulse rides on the first cycle of the new slot 0.
              slot_q   <= slot_nxt;
              {a, b}   <= sel_code(slot_nxt);
              slot_idx <= slot_nxt;
              done     <= (slot_q == 2'd3);
            end
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
            done   <= 1'b0;
          end
        end

        StDone: begin
          // Start is deliberately ignored here; the earliest restart is the first IDLE cycle.
          state_q    <= StIdle;
          pcnt_q     <= '0;
          slot_q     <= 2'd0;
          loop_q     <= 1'b0;
          a          <= 1'b0;
          b          <= 1'b0;
          slot_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          slot_idx   <= 2'd0;
        end

        default: begin
          state_q    <= StIdle;
          pcnt_q     <= '0;
          slot_q     <= 2'd0;
          loop_q     <= 1'b0;
          a          <= 1'b0;
          b          <= 1'b0;
          slot_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          slot_idx   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_addr_sequencer.sv
// Scoreboard bench for dec_addr_sequencer: three instances (PRESCALE 4, 2, 1), per-cycle
// expected output words queued at stimulus time and compared on the falling edge.
module tb_dec_addr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_v [3];
  logic       loop_v  [3];
  logic       abort_v [3];
  logic       a_v     [3];
  logic       b_v     [3];
  logic       valid_v [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [1:0] idx_v   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned P = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    dec_addr_sequencer #(
      .PRESCALE(P),
      .CNT_W   (8)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_v[g]),
      .loop      (loop_v[g]),
      .abort     (abort_v[g]),
      .a         (a_v[g]),
      .b         (b_v[g]),
      .slot_valid(valid_v[g]),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .slot_idx  (idx_v[g])
    );
  end

  // Output word layout: {a, b, slot_valid, busy, done, slot_idx[1:0]}
  localparam logic [6:0] IdleW = 7'b00_000_00;
  localparam logic [6:0] DoneW = 7'b00_001_00;

  logic [6:0] exp_q [$];
  int         act;
  bit         mon_en;
  int         cyc;
  int         n_checks;
  int         n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] sel(input int s);
    logic [1:0] c;
`ifdef DEC_ADDR_SEQ_GRAY_EN
    case (s)
      0: c = 2'b00;
      1: c = 2'b01;
      2: c = 2'b11;
      default: c = 2'b10;
    endcase
`else
    c = 2'(s);
`endif
    return c;
  endfunction

  task automatic push_run(input int p, input int len, input bit lp);
    for (int c = 0; c < len; c++) begin
      int  s;
      bit  dn;
      s  = (c / p) % 4;
      dn = lp && (c > 0) && ((c % (4 * p)) == 0);
      exp_q.push_back({sel(s), 1'b1, 1'b1, dn, 2'(s)});
    end
  endtask

  task automatic push_sweep(input int p);
    exp_q.push_back(IdleW);
    push_run(p, 4 * p, 1'b0);
    exp_q.push_back(DoneW);
  endtask

  // Called just after a rising edge. start is sampled on edges 1..hold; abort (if abort_at > 0)
  // is sampled on edge abort_at+1.
  task automatic fire(input bit lp, input int hold, input int abort_at);
    start_v[act] = 1'b1;
    loop_v[act]  = lp;
    for (int i = 1; i <= hold || (abort_at > 0 && i <= abort_at + 1); i++) begin
      @(posedge clk);
      #1;
      if (i == hold) begin
        start_v[act] = 1'b0;
        loop_v[act]  = 1'b0;
      end
      if (abort_at > 0 && i == abort_at) abort_v[act] = 1'b1;
      if (abort_at > 0 && i == abort_at + 1) abort_v[act] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [6:0] e;
    logic [6:0] o;
    if (mon_en) begin
      for (int g = 0; g < 3; g++) begin
        e = IdleW;
        if (g == act && exp_q.size() > 0) e = exp_q.pop_front();
        o = {a_v[g], b_v[g], valid_v[g], busy_v[g], done_v[g], idx_v[g]};
        check($sformatf("dut%0d_cyc%0d", g, cyc), {25'b0, o}, {25'b0, e});
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    mon_en   = 1'b0;
    act      = 0;
    for (int g = 0; g < 3; g++) begin
      start_v[g] = 1'b1;
      loop_v[g]  = 1'b1;
      abort_v[g] = 1'b0;
    end

    // Reset held two cycles with start high: nothing may start.
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start_v[g] = 1'b0;
      loop_v[g]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;

    // PRESCALE=4 single sweep.
    act = 0;
    push_sweep(4);
    fire(1'b0, 1, 0);
    drain();

    // Abort in the first cycle of slot 2, then a fresh sweep from slot 0.
    exp_q.push_back(IdleW);
    push_run(4, 9, 1'b0);
    fire(1'b0, 1, 9);
    drain();
    push_sweep(4);
    fire(1'b0, 1, 0);
    drain();

    // Start and abort together in IDLE: abort wins.
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Start held through the sweep and the DONE cycle: exactly one sweep.
    push_sweep(4);
    fire(1'b0, 18, 0);
    drain();

    // Held one edge longer: restart on the first IDLE cycle.
    push_sweep(4);
    push_sweep(4);
    fire(1'b0, 19, 0);
    drain();

    // PRESCALE=2 continuous loop, loop input dropped after start, then abort.
    act = 1;
    exp_q.push_back(IdleW);
    push_run(2, 27, 1'b1);
    fire(1'b1, 1, 27);
    drain();

    // PRESCALE=1 single sweep and a short loop with abort.
    act = 2;
    push_sweep(1);
    fire(1'b0, 1, 0);
    drain();
    exp_q.push_back(IdleW);
    push_run(1, 10, 1'b1);
    fire(1'b1, 1, 10);
    drain();

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
